// File: rtl/rf_pkg.sv
// Shared register-file constants used by the write arbiter and its queue.
// Holds the datapath widths, the register count, the PC index, the
// requester slot numbering and a small wrap-around helper.
package rf_pkg;

    localparam int RF_DW     = 32;  // register data width
    localparam int RF_AW     = 4;   // register address width
    localparam int RF_NREGS  = 16;  // number of architectural registers
    localparam int RF_PC_IDX = 15;  // R15 holds the PC

    // Requester slot numbering on the arbiter's req_* buses.
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
    localparam int REQ_PC  = 2;

    localparam int WQ_DEPTH = 2;    // write-queue entries

    // Wraps idx back into 0..n-1. idx is never more than 2n-2 here.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rf_wq.sv
// rf_wq: 2-entry in-order write queue in front of the register-file
// write port.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   push, push_addr/data  enqueue one {addr, data} entry
//   pop                   dequeue the head entry
//   full, empty           occupancy flags
//   head_addr/head_data   head entry, forced to 0 while empty
//   pending               bit r set while any queued entry targets register r
module rf_wq
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               push,
    input  logic [AW-1:0]      push_addr,
    input  logic [DW-1:0]      push_data,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic [AW-1:0]      head_addr,
    output logic [DW-1:0]      head_data,
    output logic [2**AW-1:0]   pending
);

    logic [AW-1:0] addr_mem [WQ_DEPTH];
    logic [DW-1:0] data_mem [WQ_DEPTH];
    logic          head_ptr;
    logic          tail_ptr;
    logic [1:0]    count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) tail_ptr <= ~tail_ptr;
            if (pop)  head_ptr <= ~head_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage has no reset; count alone decides which entries
    // are valid, and every output derived from it masks stale contents.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[tail_ptr] <= push_addr;
            data_mem[tail_ptr] <= push_data;
        end
    end

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign head_addr = empty ? '0 : addr_mem[head_ptr];
    assign head_data = empty ? '0 : data_mem[head_ptr];

    // An entry is occupied when the queue is full, or when it is the head
    // of a one-entry queue.
    // NOTE: pending is cleared before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        pending = '0;
        for (int e = 0; e < WQ_DEPTH; e++) begin
            if (full || (count == 2'd1 && head_ptr == 1'(e)))
                pending[addr_mem[e]] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port among
// NREQ producers using round-robin arbitration and a 2-entry write queue.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   req_valid   per-requester write request
//   req_addr    packed target registers, slice [i*AW +: AW]
//   req_data    packed write data, slice [i*DW +: DW]
//   req_ready   one-hot grant, gated by queue space
//   hold        stops draining of the queue
//   PW, RW, E   register-file write data / address / enable
//   pending     registers with a queued, not yet written, update
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = RF_DW,
    parameter int AW   = RF_AW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 hold,
    output logic [DW-1:0]        PW,
    output logic [AW-1:0]        RW,
    output logic                 E,
    output logic [2**AW-1:0]     pending
);

    localparam int RRW = $clog2(NREQ);

    logic [RRW-1:0]  rr;
    logic [RRW-1:0]  sel;
    logic [NREQ-1:0] grant;
    logic            found;
    logic            space;
    logic            push;
    logic            full;
    logic            empty;

    // First valid requester at or after rr, scanning modulo NREQ.
    always_comb begin
        int idx;
        grant = '0;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_wrap(int'(rr) + k, NREQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                sel        = RRW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    // Draining is blocked by hold and by reset; a full queue still accepts
    // a new write in a cycle where the head is popping.
    assign E         = ~empty & ~hold & ~RST;
    assign space     = ~RST & (~full | E);
    assign req_ready = space ? grant : '0;
    assign push      = space & found;

    always_ff @(posedge CLK) begin
        if (RST)
            rr <= '0;
        else if (push)
            rr <= (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
    end

    rf_wq #(
        .DW (DW),
        .AW (AW)
    ) u_wq (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_addr (req_addr[sel*AW +: AW]),
        .push_data (req_data[sel*DW +: DW]),
        .pop       (E),
        .full      (full),
        .empty     (empty),
        .head_addr (RW),
        .head_data (PW),
        .pending   (pending)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 3;
    localparam int DW   = RF_DW;
    localparam int AW   = RF_AW;

    logic                CLK = 1'b0;
    logic                RST;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                hold;
    logic [DW-1:0]       PW;
    logic [AW-1:0]       RW;
    logic                E;
    logic [2**AW-1:0]    pending;

    rf_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .PW        (PW),
        .RW        (RW),
        .E         (E),
        .pending   (pending)
    );

    always #5 CLK = ~CLK;

    // Register file fed by the DUT's write port.
    logic [DW-1:0] rf_dut [RF_NREGS];
    always @(posedge CLK) if (E) rf_dut[RW] <= PW;

    // Reference model: a plain FIFO of writes, a round-robin index and the
    // register contents that the writes should produce.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           mq[$];
    int            mrr;
    logic [DW-1:0] mrf [RF_NREGS];

    int checks = 0;
    int errors = 0;

    logic [NREQ-1:0]  obs_ready;
    logic             obs_e;
    logic [2**AW-1:0] obs_pend;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model across the rising edge.
    task automatic do_cycle(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                            input logic [NREQ*DW-1:0] d, input logic h, input logic r);
        logic             exp_e;
        logic             space;
        int               g;
        int               idx;
        logic [NREQ-1:0]  exp_ready;
        logic [DW-1:0]    exp_pw;
        logic [AW-1:0]    exp_rw;
        logic [2**AW-1:0] exp_pend;
        wr_t              w;

        req_valid = v;
        req_addr  = a;
        req_data  = d;
        hold      = h;
        RST       = r;
        #2;

        exp_e = (mq.size() != 0) && !h && !r;
        space = !r && ((mq.size() < 2) || exp_e);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mrr + k) % NREQ;
            if (g < 0 && v[idx]) g = idx;
        end
        exp_ready = '0;
        if (space && g >= 0) exp_ready[g] = 1'b1;
        exp_pw = '0;
        exp_rw = '0;
        if (mq.size() != 0) begin
            exp_pw = mq[0].data;
            exp_rw = mq[0].addr;
        end
        exp_pend = '0;
        foreach (mq[i]) exp_pend[mq[i].addr] = 1'b1;

        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("E",         64'(E),         64'(exp_e));
        check("PW",        64'(PW),        64'(exp_pw));
        check("RW",        64'(RW),        64'(exp_rw));
        check("pending",   64'(pending),   64'(exp_pend));
        obs_ready = req_ready;
        obs_e     = E;
        obs_pend  = pending;

        @(posedge CLK);
        if (r) begin
            mq.delete();
            mrr = 0;
        end else begin
            if (exp_e) begin
                mrf[mq[0].addr] = mq[0].data;
                void'(mq.pop_front());
            end
            if (exp_ready != '0) begin
                w.addr = a[g*AW +: AW];
                w.data = d[g*DW +: DW];
                mq.push_back(w);
                mrr = (g + 1) % NREQ;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle('0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [NREQ-1:0]    rv;
        logic [NREQ*AW-1:0] ra;
        logic [NREQ*DW-1:0] rd;
        logic               rh;
        logic               rr_st;

        for (int i = 0; i < RF_NREGS; i++) begin
            rf_dut[i] = '0;
            mrf[i]    = '0;
        end
        mrr       = 0;
        RST       = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #1;

        // Reset with every requester asking.
        for (int i = 0; i < 2; i++) begin
            do_cycle('1, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b1);
            check("reset_E", 64'(obs_e), 64'd0);
            check("reset_ready", 64'(obs_ready), 64'd0);
            check("reset_pending", 64'(obs_pend), 64'd0);
        end

        // Round-robin: all valid, grants rotate 0,1,2,0.
        do_cycle('1, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
        check("first_grant", 64'(obs_ready), 64'b001);
        do_cycle('1, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
        check("rr_grant1", 64'(obs_ready), 64'b010);
        do_cycle('1, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
        check("rr_grant2", 64'(obs_ready), 64'b100);
        do_cycle('1, {4'd3, 4'd2, 4'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 1'b0);
        check("rr_grant0", 64'(obs_ready), 64'b001);
        idle(3);

        // Single write from the load port.
        do_cycle(3'b010, {4'd0, 4'd5, 4'd0}, {32'h0, 32'hAABBCCDD, 32'h0}, 1'b0, 1'b0);
        do_cycle('0, '0, '0, 1'b0, 1'b0);
        check("single_E", 64'(obs_e), 64'd1);
        check("single_pend5", 64'(obs_pend[5]), 64'd1);
        idle(1);
        check("single_rf5", 64'(rf_dut[5]), 64'hAABBCCDD);
        check("single_pend_clear", 64'(obs_pend), 64'd0);

        // Hold: two accepts fill the queue, then ready closes.
        do_cycle(3'b001, {4'd0, 4'd0, 4'd10}, {32'h0, 32'h0, 32'h11223344}, 1'b1, 1'b0);
        do_cycle(3'b100, {4'd15, 4'd0, 4'd0}, {32'hFFFFFFFF, 32'h0, 32'h0}, 1'b1, 1'b0);
        do_cycle(3'b101, {4'd15, 4'd0, 4'd10}, {32'h5, 32'h0, 32'h6}, 1'b1, 1'b0);
        check("full_ready", 64'(obs_ready), 64'd0);
        check("full_pending", 64'(obs_pend), 64'h8400);
        check("full_noE", 64'(obs_e), 64'd0);
        do_cycle(3'b001, {4'd0, 4'd0, 4'd9}, {32'h0, 32'h0, 32'h99}, 1'b0, 1'b0);
        check("reopen_E", 64'(obs_e), 64'd1);
        check("reopen_ready", 64'(obs_ready), 64'b001);
        idle(3);
        check("hold_rf10", 64'(rf_dut[10]), 64'h11223344);
        check("hold_rf15", 64'(rf_dut[15]), 64'hFFFFFFFF);

        // Same address back to back.
        do_cycle(3'b001, {4'd0, 4'd0, 4'd7}, {32'h0, 32'h0, 32'hA}, 1'b0, 1'b0);
        do_cycle(3'b010, {4'd0, 4'd7, 4'd0}, {32'h0, 32'hB, 32'h0}, 1'b0, 1'b0);
        do_cycle('0, '0, '0, 1'b0, 1'b0);
        check("same_pend7", 64'(obs_pend[7]), 64'd1);
        idle(2);
        check("same_rf7", 64'(rf_dut[7]), 64'hB);

        // Mid-operation reset discards a full queue.
        do_cycle(3'b001, {4'd0, 4'd0, 4'd12}, {32'h0, 32'h0, 32'hDEAD}, 1'b1, 1'b0);
        do_cycle(3'b010, {4'd0, 4'd13, 4'd0}, {32'h0, 32'hBEEF, 32'h0}, 1'b1, 1'b0);
        do_cycle('0, '0, '0, 1'b1, 1'b1);
        idle(3);
        check("rst_pending", 64'(obs_pend), 64'd0);
        check("rst_rf12", 64'(rf_dut[12]), 64'd0);
        check("rst_rf13", 64'(rf_dut[13]), 64'd0);

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            rv = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                ra[i*AW +: AW] = AW'($urandom);
                rd[i*DW +: DW] = $urandom;
            end
            rh    = ($urandom_range(0, 3) == 0);
            rr_st = ($urandom_range(0, 49) == 0);
            do_cycle(rv, ra, rd, rh, rr_st);
        end
        idle(4);

        for (int i = 0; i < RF_NREGS; i++)
            check($sformatf("rf_final_%0d", i), 64'(rf_dut[i]), 64'(mrf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
